// File: rtl/prbs_rd_checker.sv
// Read-data PRBS checker: regenerates the command generator's 32-bit Galois LFSR
// stream and compares it beat by beat against returning read data.
module prbs_rd_checker #(
    parameter int DWIDTH    = 32,
    parameter int CNT_WIDTH = 16,
    parameter int TCQ       = 100
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 seed_load_i,
    input  logic [31:0]          seed_i,
    input  logic                 data_valid_i,
    input  logic [DWIDTH-1:0]    data_i,
    output logic                 error_pulse_o,
    output logic                 error_o,
    output logic [CNT_WIDTH-1:0] err_cnt_o,
    output logic [31:0]          beat_cnt_o,
    output logic [DWIDTH-1:0]    first_err_data_o,
    output logic [DWIDTH-1:0]    first_err_exp_o,
    output logic [31:0]          first_err_beat_o,
    output logic                 checking_o
);

    localparam int LANES = DWIDTH / 32;

    if ((DWIDTH % 32) != 0 || DWIDTH < 32 || TCQ < 0) begin : g_param_check
        $error("prbs_rd_checker: DWIDTH must be a positive multiple of 32 and TCQ non-negative");
    end

    typedef enum logic [1:0] {IDLE, CHECK, FAIL} state_t;

    state_t            state;
    logic [31:0]       lfsr;
    logic [31:0]       lfsr_next;
    logic [31:0]       seed_fix;
    logic [DWIDTH-1:0] exp_word;
    logic              compare;
    logic              mismatch;

    // Bit k of lfsr holds q(k+1) of the polynomial description.
    assign lfsr_next = {lfsr[30:7],
                        lfsr[31] ^ lfsr[6],
                        lfsr[31] ^ lfsr[5],
                        lfsr[4:2],
                        lfsr[31] ^ lfsr[1],
                        lfsr[0],
                        lfsr[31]};

    // An all-zero seed would lock the LFSR at zero forever.
    assign seed_fix = (seed_i == 32'h0) ? 32'h0000_0001 : seed_i;
    assign exp_word = {LANES{lfsr}};
    assign compare  = (state != IDLE) && data_valid_i && !seed_load_i;
    assign mismatch = compare && (data_i != exp_word);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= IDLE;
            lfsr             <= 32'h0000_0001;
            error_pulse_o    <= 1'b0;
            error_o          <= 1'b0;
            err_cnt_o        <= '0;
            beat_cnt_o       <= '0;
            first_err_data_o <= '0;
            first_err_exp_o  <= '0;
            first_err_beat_o <= '0;
            checking_o       <= 1'b0;
        end else begin
            // NOTE: the strobe defaults low every cycle so it lasts exactly one beat.
            error_pulse_o <= 1'b0;
            if (clr_i) begin
                error_o          <= 1'b0;
                err_cnt_o        <= '0;
                beat_cnt_o       <= '0;
                first_err_data_o <= '0;
                first_err_exp_o  <= '0;
                first_err_beat_o <= '0;
                state            <= seed_load_i ? CHECK : IDLE;
                checking_o       <= seed_load_i;
                if (seed_load_i) begin
                    lfsr <= seed_fix;
                end
            end else if (seed_load_i) begin
                lfsr       <= seed_fix;
                state      <= CHECK;
                checking_o <= 1'b1;
            end else if (compare) begin
                beat_cnt_o <= beat_cnt_o + 32'd1;
                lfsr       <= lfsr_next;
                if (mismatch) begin
                    error_pulse_o <= 1'b1;
                    error_o       <= 1'b1;
                    state         <= FAIL;
                    if (err_cnt_o != '1) begin
                        err_cnt_o <= err_cnt_o + 1'b1;
                    end
                    // Only the first failure since the last clear is kept for debug.
                    if (!error_o) begin
                        first_err_data_o <= data_i;
                        first_err_exp_o  <= exp_word;
                        first_err_beat_o <= beat_cnt_o;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_prbs_rd_checker.sv
// Scoreboard bench for prbs_rd_checker at DWIDTH=128, CNT_WIDTH=4: every driven
// cycle pushes the expected register state, popped and compared one edge later.
module tb_prbs_rd_checker;

    localparam int DW    = 128;
    localparam int CW    = 4;
    localparam int LANES = DW / 32;

    typedef struct {
        logic          pulse;
        logic          error;
        logic [CW-1:0] err_cnt;
        logic [31:0]   beat;
        logic [DW-1:0] cap_data;
        logic [DW-1:0] cap_exp;
        logic [31:0]   cap_beat;
        logic          checking;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          seed_load = 1'b0;
    logic [31:0]   seed = '0;
    logic          data_valid = 1'b0;
    logic [DW-1:0] data = '0;
    logic          error_pulse;
    logic          error;
    logic [CW-1:0] err_cnt;
    logic [31:0]   beat_cnt;
    logic [DW-1:0] first_err_data;
    logic [DW-1:0] first_err_exp;
    logic [31:0]   first_err_beat;
    logic          checking;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb[$];

    // Reference model state
    logic [31:0]   m_lfsr;
    int            m_state;
    logic          m_err;
    logic [CW-1:0] m_err_cnt;
    logic [31:0]   m_beat;
    logic [DW-1:0] m_cap_data;
    logic [DW-1:0] m_cap_exp;
    logic [31:0]   m_cap_beat;

    prbs_rd_checker #(.DWIDTH(DW), .CNT_WIDTH(CW), .TCQ(100)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .clr_i            (clr),
        .seed_load_i      (seed_load),
        .seed_i           (seed),
        .data_valid_i     (data_valid),
        .data_i           (data),
        .error_pulse_o    (error_pulse),
        .error_o          (error),
        .err_cnt_o        (err_cnt),
        .beat_cnt_o       (beat_cnt),
        .first_err_data_o (first_err_data),
        .first_err_exp_o  (first_err_exp),
        .first_err_beat_o (first_err_beat),
        .checking_o       (checking)
    );

    always #5 clk = ~clk;

    // Galois step written as rotate-left plus tap mask.
    function automatic logic [31:0] prbs_next(input logic [31:0] q);
        return {q[30:0], q[31]} ^ (q[31] ? 32'h0000_00C4 : 32'h0);
    endfunction

    function automatic logic [DW-1:0] rep(input logic [31:0] w);
        return {LANES{w}};
    endfunction

    task automatic model_reset();
        m_lfsr = 32'h1; m_state = 0; m_err = 1'b0; m_err_cnt = '0; m_beat = '0;
        m_cap_data = '0; m_cap_exp = '0; m_cap_beat = '0;
    endtask

    task automatic step(input string tag, input logic c, input logic ld,
                        input logic [31:0] sd, input logic v, input logic [DW-1:0] d);
        exp_t e;
        exp_t g;
        logic [DW-1:0] ew;
        e.pulse = 1'b0;
        if (c) begin
            m_err = 1'b0; m_err_cnt = '0; m_beat = '0;
            m_cap_data = '0; m_cap_exp = '0; m_cap_beat = '0;
            m_state = ld ? 1 : 0;
            if (ld) m_lfsr = (sd == 0) ? 32'h1 : sd;
        end else if (ld) begin
            m_lfsr = (sd == 0) ? 32'h1 : sd;
            m_state = 1;
        end else if (v && m_state != 0) begin
            ew = rep(m_lfsr);
            if (d !== ew) begin
                e.pulse = 1'b1;
                if (m_err_cnt != {CW{1'b1}}) m_err_cnt = m_err_cnt + 1'b1;
                if (!m_err) begin
                    m_cap_data = d; m_cap_exp = ew; m_cap_beat = m_beat;
                end
                m_err = 1'b1;
                m_state = 2;
            end
            m_beat = m_beat + 32'd1;
            m_lfsr = prbs_next(m_lfsr);
        end
        e.error = m_err; e.err_cnt = m_err_cnt; e.beat = m_beat;
        e.cap_data = m_cap_data; e.cap_exp = m_cap_exp; e.cap_beat = m_cap_beat;
        e.checking = (m_state != 0);
        sb.push_back(e);

        clr = c; seed_load = ld; seed = sd; data_valid = v; data = d;
        @(posedge clk); #1;
        clr = 1'b0; seed_load = 1'b0; data_valid = 1'b0;

        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue, required one entry", tag);
        end else begin
            g = sb.pop_front();
            if (error_pulse !== g.pulse || error !== g.error || err_cnt !== g.err_cnt ||
                beat_cnt !== g.beat || checking !== g.checking) begin
                n_fail++;
                $display("FAIL %s status: got pulse=%b err=%b cnt=%0d beat=%0d chk=%b, required pulse=%b err=%b cnt=%0d beat=%0d chk=%b",
                         tag, error_pulse, error, err_cnt, beat_cnt, checking,
                         g.pulse, g.error, g.err_cnt, g.beat, g.checking);
            end
            n_checks++;
            if (first_err_data !== g.cap_data || first_err_exp !== g.cap_exp ||
                first_err_beat !== g.cap_beat) begin
                n_fail++;
                $display("FAIL %s capture: got data=%h exp=%h beat=%0d, required data=%h exp=%h beat=%0d",
                         tag, first_err_data, first_err_exp, first_err_beat,
                         g.cap_data, g.cap_exp, g.cap_beat);
            end
        end
    endtask

    task automatic expect_all_zero(input string tag);
        n_checks++;
        if (error_pulse !== 1'b0 || error !== 1'b0 || err_cnt !== '0 || beat_cnt !== '0 ||
            first_err_data !== '0 || first_err_exp !== '0 || first_err_beat !== '0 ||
            checking !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got pulse=%b err=%b cnt=%0d beat=%0d cap_beat=%0d chk=%b, required all zero",
                     tag, error_pulse, error, err_cnt, beat_cnt, first_err_beat, checking);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        expect_all_zero("reset_values");
        step("idle_beat_ignored", 1'b0, 1'b0, 32'h0, 1'b1, rep(32'hDEAD_BEEF));
    endtask

    task automatic test_seed_one();
        step("seed1_load", 1'b0, 1'b1, 32'h1, 1'b0, '0);
        step("seed1_beat0", 1'b0, 1'b0, 32'h0, 1'b1, rep(32'h0000_0001));
        step("seed1_beat1", 1'b0, 1'b0, 32'h0, 1'b1, rep(32'h0000_0002));
        n_checks++;
        if (beat_cnt !== 32'd2 || err_cnt !== '0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL seed1_totals: got beat=%0d err_cnt=%0d, required beat=2 err_cnt=0", beat_cnt, err_cnt);
        end
    endtask

    task automatic test_taps();
        step("taps_clr_load", 1'b1, 1'b1, 32'h8000_0000, 1'b0, '0);
        step("taps_b0", 1'b0, 1'b0, 32'h0, 1'b1, rep(32'h8000_0000));
        step("taps_b1_good", 1'b0, 1'b0, 32'h0, 1'b1, rep(32'h0000_00C5));
        step("taps_reload", 1'b1, 1'b1, 32'h8000_0000, 1'b0, '0);
        step("taps_b0_again", 1'b0, 1'b0, 32'h0, 1'b1, rep(32'h8000_0000));
        step("taps_b1_bad", 1'b0, 1'b0, 32'h0, 1'b1, rep(32'h0000_00C4));
        n_checks++;
        if (error_pulse !== 1'b1 || first_err_exp !== rep(32'hC5) ||
            first_err_data !== rep(32'hC4) || first_err_beat !== 32'd1) begin
            n_fail++;
            $display("FAIL taps_capture: got pulse=%b exp=%h data=%h beat=%0d, required pulse=1 exp=C5 data=C4 beat=1",
                     error_pulse, first_err_exp, first_err_data, first_err_beat);
        end
        step("taps_pulse_drops", 1'b0, 1'b0, 32'h0, 1'b0, '0);
    endtask

    task automatic test_wide();
        logic [31:0]   q;
        logic [DW-1:0] d;
        step("wide_load", 1'b1, 1'b1, 32'h1234_5678, 1'b0, '0);
        q = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            d = rep(q);
            if (i == 3) d[100] = ~d[100];
            step($sformatf("wide_b%0d", i), 1'b0, 1'b0, 32'h0, 1'b1, d);
            q = prbs_next(q);
        end
        n_checks++;
        if (err_cnt !== 4'd1 || first_err_beat !== 32'd3 || error !== 1'b1 || checking !== 1'b1) begin
            n_fail++;
            $display("FAIL wide_fail_state: got err_cnt=%0d beat=%0d err=%b chk=%b, required 1 3 1 1",
                     err_cnt, first_err_beat, error, checking);
        end
        // Reload from FAIL keeps the sticky error and the capture.
        step("wide_reload", 1'b0, 1'b1, 32'hCAFE_0001, 1'b0, '0);
        step("wide_after_reload", 1'b0, 1'b0, 32'h0, 1'b1, rep(32'hCAFE_0001));
        step("wide_gap", 1'b0, 1'b0, 32'h0, 1'b0, '0);
        step("wide_after_gap", 1'b0, 1'b0, 32'h0, 1'b1, rep(prbs_next(32'hCAFE_0001)));
    endtask

    task automatic test_load_priority();
        step("prio_clr", 1'b1, 1'b0, 32'h0, 1'b0, '0);
        step("prio_load_with_valid", 1'b0, 1'b1, 32'h0, 1'b1, rep(32'hFFFF_FFFF));
        n_checks++;
        if (beat_cnt !== 32'd0 || error_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_not_counted: got beat=%0d pulse=%b, required beat=0 pulse=0", beat_cnt, error_pulse);
        end
        step("prio_seed0_beat", 1'b0, 1'b0, 32'h0, 1'b1, rep(32'h0000_0001));
    endtask

    task automatic test_saturation();
        step("sat_load", 1'b1, 1'b1, 32'h5A5A_5A5A, 1'b0, '0);
        for (int i = 0; i < 20; i++) begin
            if (i == 10) step("sat_gap", 1'b0, 1'b0, 32'h0, 1'b0, '0);
            step($sformatf("sat_b%0d", i), 1'b0, 1'b0, 32'h0, 1'b1, ~rep(m_lfsr));
        end
        n_checks++;
        if (err_cnt !== 4'd15 || first_err_beat !== 32'd0 || beat_cnt !== 32'd20 ||
            first_err_exp !== rep(32'h5A5A_5A5A)) begin
            n_fail++;
            $display("FAIL sat_totals: got err_cnt=%0d cap_beat=%0d beat=%0d, required 15 0 20",
                     err_cnt, first_err_beat, beat_cnt);
        end
    endtask

    task automatic test_clear_idle();
        step("clr_to_idle", 1'b1, 1'b0, 32'h0, 1'b0, '0);
        step("clr_ignored_beat0", 1'b0, 1'b0, 32'h0, 1'b1, rep(32'h1111_2222));
        step("clr_ignored_beat1", 1'b0, 1'b0, 32'h0, 1'b1, rep(32'h3333_4444));
        n_checks++;
        if (beat_cnt !== 32'd0 || checking !== 1'b0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_idle: got beat=%0d chk=%b err=%b, required 0 0 0", beat_cnt, checking, error);
        end
    endtask

    task automatic test_async_reset();
        step("ar_load", 1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, '0);
        step("ar_bad0", 1'b0, 1'b0, 32'h0, 1'b1, ~rep(m_lfsr));
        step("ar_bad1", 1'b0, 1'b0, 32'h0, 1'b1, ~rep(m_lfsr));
        data_valid = 1'b1; data = rep(32'h0);
        #2 rst = 1'b1;
        #1 expect_all_zero("async_reset_immediate");
        data_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        step("ar_post_ignored", 1'b0, 1'b0, 32'h0, 1'b1, rep(32'h0000_0001));
    endtask

    initial begin
        model_reset();
        test_reset();
        test_seed_one();
        test_taps();
        test_wide();
        test_load_priority();
        test_saturation();
        test_clear_idle();
        test_async_reset();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
